// File: rtl/uart_transmitter_if.sv
// Push/status bundle between a byte producer and uart_transmitter.
interface uart_transmitter_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             en;
  logic [7:0]       data;
  logic             send;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             out;
  logic             busy;
  logic             done;

  modport master (
    output en, data, send,
    input  full, count, out, busy, done
  );

  modport slave (
    input  en, data, send,
    output full, count, out, busy, done
  );
endinterface

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a 16x-oversampled serialiser.
module uart_transmitter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic               clk,
  input logic               rst,
  uart_transmitter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CLK_W = 4;
  localparam logic [CLK_W-1:0] CELL_LAST = CLK_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             push_c;
  logic             pop_c;

  // Serialiser state
  state_e           state_q;
  state_e           state_d;
  logic [CLK_W-1:0] clk_cnt_q;
  logic [CLK_W-1:0] clk_cnt_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             out_q;
  logic             out_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic             cell_end_c;
  logic             can_start_c;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push_c      = bus.send && !full_q;
  assign cell_end_c  = (clk_cnt_q == CELL_LAST);
  assign can_start_c = bus.en && (count_q != '0);

  // Occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO payload write (no reset needed on storage).
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  // Serialiser state register; reset truncates any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      out_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and output decode for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CLK_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pop_c     = 1'b0;

    case (state_q)
      IDLE: begin
        out_d     = 1'b1;
        busy_d    = 1'b0;
        clk_cnt_d = '0;
        if (can_start_c) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          out_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START_BIT;
        end
      end

      START_BIT: begin
        if (cell_end_c) begin
          clk_cnt_d = '0;
          out_d     = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA_BITS;
        end
      end

      DATA_BITS: begin
        if (cell_end_c) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            out_d   = 1'b1;
            state_d = STOP_BIT;
          end else begin
            shift_d   = shift_q >> 1;
            out_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP_BIT: begin
        if (cell_end_c) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          // Chain straight into the next start bit when more data is waiting.
          if (can_start_c) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            out_d   = 1'b0;
            state_d = START_BIT;
          end else begin
            out_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        out_d     = 1'b1;
        busy_d    = 1'b0;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  assign bus.out   = out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.full  = full_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter with a line-decoding receiver model.
module tb_uart_transmitter;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  uart_transmitter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_transmitter #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];

  // Receiver model: samples mid-cell on the falling edge, aborts if busy drops.
  int         mon_frame_err = 0;
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  always @(negedge clk) begin
    if (!mon_active) begin
      if (bus.out === 1'b0 && bus.busy === 1'b1) begin
        mon_active = 1'b1;
        mon_cnt    = 1;
        mon_byte   = '0;
      end
    end else if (bus.busy !== 1'b1) begin
      mon_active = 1'b0;
    end else begin
      mon_cnt++;
      if (mon_cnt == 8 && bus.out !== 1'b0) mon_frame_err++;
      if (mon_cnt >= 24 && mon_cnt <= 136 && (mon_cnt % 16) == 8)
        mon_byte = {bus.out, mon_byte[7:1]};
      if (mon_cnt == 152) begin
        if (bus.out !== 1'b1) mon_frame_err++;
        rx_q.push_back(mon_byte);
        mon_active = 1'b0;
      end
    end
  end

  // Pushes n bytes on consecutive edges; returns on the falling edge after the last push.
  task automatic push_burst(input logic [7:0] bs [6], input int n, input bit track);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.data = bs[i];
      bus.send = 1'b1;
      if (track) exp_q.push_back(bs[i]);
    end
    @(negedge clk);
    bus.send = 1'b0;
  endtask

  // Bounded wait for the receiver model to collect n frames.
  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (rx_q.size() < n) begin
      n_err++;
      $display("FAIL %s_timeout: frames=%0d required=%0d", name, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.send = 1'b0; bus.data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.out !== 1'b1)  begin n_err++; $display("FAIL reset_out: got %b want 1", bus.out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] bs [6];
    logic [9:0] frame;
    int viol = 0;
    logic [7:0] e, r;
    bs = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame = {1'b1, 8'hA5, 1'b0};
    bus.en = 1'b1;
    push_burst(bs, 1, 1'b1);
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL single_count_after_push: got %0d want 1", bus.count); end
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (bus.out !== frame[i/16] || bus.busy !== 1'b1 || bus.done !== 1'b0) viol++;
    end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL single_waveform: bad cycles=%0d want 0", viol); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL single_done_pulse: got %b want 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL single_done_width: got %b want 0", bus.done); end
    wait_rx(1, 20, "single");
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++; if (r !== e) begin n_err++; $display("FAIL single_byte: got %h want %h", r, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bs [6];
    int dones [$];
    int gaps = 0;
    logic [7:0] e, r;
    bs = '{8'h00, 8'hFF, 8'h3C, 8'h00, 8'h00, 8'h00};
    bus.en = 1'b1;
    push_burst(bs, 3, 1'b1);
    // Index k here means the falling edge after the k-th edge past the first push.
    if (bus.busy !== 1'b1) gaps++;
    for (int k = 3; k <= 520; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones.push_back(k);
      if (k <= 480 && bus.busy !== 1'b1) gaps++;
    end
    n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL b2b_busy_gap: gap cycles=%0d want 0", gaps); end
    n_cmp++;
    if (dones.size() != 3 || dones[0] != 161 || dones[1] != 321 || dones[2] != 481) begin
      n_err++;
      $display("FAIL b2b_done_times: got %p want '{161, 321, 481}", dones);
    end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL b2b_count: got %0d want 0", bus.count); end
    wait_rx(3, 20, "b2b");
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++; if (r !== e) begin n_err++; $display("FAIL b2b_byte: got %h want %h", r, e); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bs [6];
    int want;
    logic [7:0] e, r;
    bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        want = (i > 4) ? 4 : i;
        n_cmp++; if (bus.count !== 3'(want)) begin n_err++; $display("FAIL ovf_count_%0d: got %0d want %0d", i, bus.count, want); end
        n_cmp++; if (bus.full !== (i >= 4)) begin n_err++; $display("FAIL ovf_full_%0d: got %b want %b", i, bus.full, i >= 4); end
      end
      bus.data = bs[i];
      bus.send = 1'b1;
      if (i < 4) exp_q.push_back(bs[i]);
    end
    @(negedge clk);
    bus.send = 1'b0;
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL ovf_count_final: got %0d want 4", bus.count); end
    @(negedge clk);
    bus.en = 1'b1;
    wait_rx(4, 700, "ovf");
    repeat (20) @(negedge clk);
    n_cmp++; if (rx_q.size() != 4) begin n_err++; $display("FAIL ovf_frames: got %0d want 4", rx_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++; if (r !== e) begin n_err++; $display("FAIL ovf_byte: got %h want %h", r, e); end
    end
    rx_q.delete();
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL ovf_full_drained: got %b want 0", bus.full); end
  endtask

  task automatic test_enable_drop();
    logic [7:0] bs [6];
    int k = 0;
    int viol = 0;
    logic [7:0] e, r;
    bs = '{8'hC3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.en = 1'b1;
    push_burst(bs, 2, 1'b1);
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    while (bus.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL endrop_done: got %b want 1", bus.done); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out !== 1'b1 || bus.count !== 3'd1 || bus.busy !== 1'b0) viol++;
    end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL endrop_hold: bad cycles=%0d want 0", viol); end
    bus.en = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out !== 1'b0) begin n_err++; $display("FAIL endrop_restart_out: got %b want 0", bus.out); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL endrop_restart_count: got %0d want 0", bus.count); end
    wait_rx(2, 200, "endrop");
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++; if (r !== e) begin n_err++; $display("FAIL endrop_byte: got %h want %h", r, e); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] bs [6];
    int viol = 0;
    bs = '{8'hF0, 8'h0F, 8'h99, 8'h00, 8'h00, 8'h00};
    bus.en = 1'b1;
    push_burst(bs, 3, 1'b0);
    repeat (48) @(negedge clk);
    n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL rstmid_queued: got %0d want 2", bus.count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.out !== 1'b1)  begin n_err++; $display("FAIL rstmid_out: got %b want 1", bus.out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) viol++;
    end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL rstmid_quiet: bad cycles=%0d want 0", viol); end
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL rstmid_frames: got %0d want 0", rx_q.size()); end
    rx_q.delete();
  endtask

  task automatic test_loopback();
    logic [7:0] bs [6];
    logic [7:0] e, r;
    bs = '{8'h55, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.en = 1'b1;
    push_burst(bs, 2, 1'b1);
    wait_rx(2, 400, "loopback");
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++; if (r !== e) begin n_err++; $display("FAIL loopback_byte: got %h want %h", r, e); end
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (mon_frame_err != 0) begin n_err++; $display("FAIL framing_errors: got %0d want 0", mon_frame_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_enable_drop();
    test_reset_midframe();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
